// File: rtl/cpu_pkg.sv
// Shared pipeline control codes: writeback selects, redirect kinds,
// PC source selects and the stall/flush sequencer state encoding.
package cpu_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_BRANCH = 2'b01;
    localparam logic [1:0] BR_JUMP   = 2'b10;

    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_MEM_WAIT = 2'b01,
        CTRL_FAULT    = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and per-register hold/bubble controls.
// master: pipeline side (drives hazard info); slave: the sequencer.
interface pipeline_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_reg_we;
    logic [1:0] ex_wb_sel;
    logic [1:0] ex_branch;
    logic       mem_req;
    logic       mem_ready;

    logic       pc_stall;
    logic       if_id_stall;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       id_ex_flush;
    logic       ex_mem_stall;
    logic       mem_wb_flush;
    logic [1:0] pc_sel;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, ex_reg_we, ex_wb_sel, ex_branch,
        output mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush,
        input  id_ex_stall, id_ex_flush, ex_mem_stall,
        input  mem_wb_flush, pc_sel
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, ex_reg_we, ex_wb_sel, ex_branch,
        input  mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush,
        output id_ex_stall, id_ex_flush, ex_mem_stall,
        output mem_wb_flush, pc_sel
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use compare: a load in EX whose rd feeds the instruction in ID.
// Ports: ID source indices/use flags, EX rd/we/wb_sel in; load_use out.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_we,
    input  logic [1:0] ex_wb_sel,
    output logic       load_use
);

    logic ex_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency
    assign ex_load  = (ex_wb_sel == WB_SEL_MEM) && ex_reg_we && (ex_rd != 5'd0);
    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = ex_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: EX redirects, ID load-use, MEM wait states,
// memory-timeout watchdog (sticky fault) and stall/flush counters.
// Ports: clk, rst, ctrl (slave bus), fault, stall_cnt, flush_cnt.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   ctrl,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e state;
    ctrl_state_e state_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_next;
    logic        freeze;
    logic        redirect;
    logic        load_use;

    hazard_detect u_hazard (
        .id_rs1      (ctrl.id_rs1),
        .id_rs2      (ctrl.id_rs2),
        .id_rs1_used (ctrl.id_rs1_used),
        .id_rs2_used (ctrl.id_rs2_used),
        .ex_rd       (ctrl.ex_rd),
        .ex_reg_we   (ctrl.ex_reg_we),
        .ex_wb_sel   (ctrl.ex_wb_sel),
        .load_use    (load_use)
    );

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        freeze     = 1'b0;
        unique case (state)
            CTRL_RUN: begin
                wait_next = 8'd0;
                freeze    = ctrl.mem_req && !ctrl.mem_ready;
                if (freeze) state_next = CTRL_MEM_WAIT;
            end
            CTRL_MEM_WAIT: begin
                freeze = !ctrl.mem_ready;
                // a completion in the last allowed cycle still rescues it
                if (ctrl.mem_ready) begin
                    state_next = CTRL_RUN;
                    wait_next  = 8'd0;
                end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                    state_next = CTRL_FAULT;
                end else begin
                    wait_next = wait_cnt + 8'd1;
                end
            end
            CTRL_FAULT: state_next = CTRL_FAULT;
            default:    state_next = CTRL_RUN;
        endcase
    end

    always_comb begin
        ctrl.pc_stall     = 1'b0;
        ctrl.if_id_stall  = 1'b0;
        ctrl.if_id_flush  = 1'b0;
        ctrl.id_ex_stall  = 1'b0;
        ctrl.id_ex_flush  = 1'b0;
        ctrl.ex_mem_stall = 1'b0;
        ctrl.mem_wb_flush = 1'b0;
        ctrl.pc_sel       = PC_SEL_PC4;
        redirect          = 1'b0;
        if (rst) begin
            redirect = 1'b0;
        end else if (state == CTRL_FAULT || freeze) begin
            // hold everything up to MEM; a pending redirect stays in EX
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ctrl.ex_branch == BR_BRANCH ||
                     ctrl.ex_branch == BR_JUMP) begin
            // the flushed ID instr makes any load-use moot
            redirect         = 1'b1;
            ctrl.pc_sel      = ctrl.ex_branch;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CTRL_RUN;
            wait_cnt  <= 8'd0;
            fault     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == CTRL_FAULT) fault <= 1'b1;
            if (ctrl.pc_stall && state != CTRL_FAULT)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: table vectors, directed multi-cycle
// sequences and random stimulus against a streak-based reference.
module tb_pipeline_ctrl;
    import cpu_pkg::*;

    localparam int TMO = 16;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] wbsel;
        logic [1:0] br;
        logic       req;
        logic       ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        fault;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl      (bus),
        .fault     (fault),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          streak;
    bit          faulted;
    int unsigned m_stall;
    int unsigned m_flush;
    logic [8:0]  last_ctl;

    // control vector: pc_stall,if_id_stall,if_id_flush,id_ex_stall,
    // id_ex_flush,ex_mem_stall,mem_wb_flush,pc_sel[1:0]
    localparam logic [8:0] C_NONE = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] C_LU   = 9'b1_1_0_0_1_0_0_00;
    localparam logic [8:0] C_BR   = 9'b0_0_1_0_1_0_0_01;
    localparam logic [8:0] C_JMP  = 9'b0_0_1_0_1_0_0_10;
    localparam logic [8:0] C_HOLD = 9'b1_1_0_1_0_1_1_00;

    function automatic in_t mk(input int rs1, input int rs2, input bit u1,
                               input bit u2, input int rd, input bit we,
                               input logic [1:0] wbsel, input logic [1:0] br,
                               input bit req, input bit ready);
        in_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.we = we;
        v.wbsel = wbsel; v.br = br;
        v.req = req; v.ready = ready;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_frozen(input in_t v);
        if (faulted) return 1'b0;
        if (streak > 0) return !v.ready;
        return v.req && !v.ready;
    endfunction

    function automatic logic [8:0] m_ctl(input in_t v, input logic r);
        bit lu;
        if (r) return C_NONE;
        if (faulted || m_frozen(v)) return C_HOLD;
        if (v.br == BR_BRANCH) return C_BR;
        if (v.br == BR_JUMP) return C_JMP;
        lu = v.wbsel == WB_SEL_MEM && v.we && v.rd != 0 &&
             ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        return lu ? C_LU : C_NONE;
    endfunction

    // fault after MEM_TIMEOUT+1 consecutive frozen cycles
    task automatic m_update(input in_t v, input logic r, input logic [8:0] e);
        if (r) begin
            streak = 0; faulted = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (e[8] && !faulted) m_stall++;
        if (e[1:0] != 2'b00) m_flush++;
        if (!faulted) begin
            if (m_frozen(v)) begin
                streak++;
                if (streak == TMO + 1) faulted = 1;
            end else begin
                streak = 0;
            end
        end
    endtask

    task automatic drive(input in_t v);
        bus.id_rs1 = v.rs1;      bus.id_rs2 = v.rs2;
        bus.id_rs1_used = v.u1;  bus.id_rs2_used = v.u2;
        bus.ex_rd = v.rd;        bus.ex_reg_we = v.we;
        bus.ex_wb_sel = v.wbsel; bus.ex_branch = v.br;
        bus.mem_req = v.req;     bus.mem_ready = v.ready;
    endtask

    task automatic tick(input in_t v, input logic r);
        logic [8:0] e;
        @(negedge clk);
        rst = r;
        drive(v);
        #1;
        e = m_ctl(v, r);
        last_ctl = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                    bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall,
                    bus.mem_wb_flush, bus.pc_sel};
        check("ctl", 64'(last_ctl), 64'(e));
        @(posedge clk);
        #1;
        m_update(v, r, e);
        check("fault", 64'(fault), 64'(faulted));
        check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    endtask

    vec_t tbl[11];
    in_t  idle;
    in_t  v;
    logic r;
    int unsigned s0;

    initial begin
        checks = 0; errors = 0;
        streak = 0; faulted = 0; m_stall = 0; m_flush = 0;
        rst = 1'b1;
        idle = mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 0, 1);
        drive(idle);

        tbl[0]  = '{mk(1, 2, 1, 1, 3, 1, WB_SEL_MEM, BR_NONE, 0, 1), C_NONE};
        tbl[1]  = '{mk(5, 2, 1, 1, 5, 1, WB_SEL_MEM, BR_NONE, 0, 1), C_LU};
        tbl[2]  = '{mk(0, 2, 1, 1, 0, 1, WB_SEL_MEM, BR_NONE, 0, 1), C_NONE};
        tbl[3]  = '{mk(1, 7, 1, 1, 7, 1, WB_SEL_MEM, BR_NONE, 0, 0), C_LU};
        tbl[4]  = '{mk(1, 7, 1, 0, 7, 1, WB_SEL_MEM, BR_NONE, 0, 1), C_NONE};
        tbl[5]  = '{mk(5, 2, 1, 1, 5, 1, WB_SEL_ALU, BR_NONE, 0, 1), C_NONE};
        tbl[6]  = '{mk(5, 2, 1, 1, 5, 0, WB_SEL_MEM, BR_NONE, 0, 1), C_NONE};
        tbl[7]  = '{mk(5, 2, 1, 1, 5, 1, WB_SEL_MEM, BR_JUMP, 0, 1), C_JMP};
        tbl[8]  = '{mk(1, 2, 1, 1, 3, 1, WB_SEL_ALU, BR_BRANCH, 0, 1), C_BR};
        tbl[9]  = '{mk(1, 2, 1, 1, 3, 1, WB_SEL_ALU, 2'b11, 0, 1), C_NONE};
        tbl[10] = '{mk(1, 2, 1, 1, 3, 1, WB_SEL_ALU, BR_BRANCH, 1, 1), C_BR};

        // reset state
        tick(idle, 1'b1);
        tick(idle, 1'b1);

        // single-cycle table
        for (int i = 0; i < 11; i++) begin
            tick(tbl[i].in, 1'b0);
            check($sformatf("tbl%0d", i), 64'(last_ctl), 64'(tbl[i].exp));
            tick(idle, 1'b0);
        end

        // load-use gives exactly one bubble: EX then holds the bubble
        tick(tbl[1].in, 1'b0);
        tick(mk(5, 2, 1, 1, 0, 0, WB_SEL_ALU, BR_NONE, 0, 1), 1'b0);
        check("lu_one_bubble", 64'(last_ctl), 64'(C_NONE));

        // 3-cycle memory wait
        s0 = stall_cnt;
        for (int i = 0; i < 3; i++) begin
            tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 0), 1'b0);
            check("memwait_hold", 64'(last_ctl), 64'(C_HOLD));
        end
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 1), 1'b0);
        check("memwait_release", 64'(last_ctl), 64'(C_NONE));
        check("memwait_stalls", 64'(stall_cnt - s0), 64'd3);

        // branch deferred behind a 2-cycle wait
        for (int i = 0; i < 2; i++) begin
            tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_BRANCH, 1, 0), 1'b0);
            check("br_deferred", 64'(last_ctl), 64'(C_HOLD));
        end
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_BRANCH, 1, 1), 1'b0);
        check("br_after_wait", 64'(last_ctl), 64'(C_BR));

        // watchdog timeout, then sticky fault
        for (int i = 0; i < TMO + 4; i++)
            tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 0), 1'b0);
        check("fault_set", 64'(fault), 64'd1);
        tick(tbl[7].in, 1'b0);
        check("fault_hold", 64'(last_ctl), 64'(C_HOLD));
        tick(idle, 1'b1);
        check("fault_clr", 64'(fault), 64'd0);

        // reset in the middle of a wait
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_JUMP, 0, 1), 1'b0);
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 0), 1'b0);
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 0), 1'b0);
        tick(mk(0, 0, 0, 0, 0, 0, WB_SEL_ALU, BR_NONE, 1, 0), 1'b1);
        check("rst_ctl", 64'(last_ctl), 64'(C_NONE));
        check("rst_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        tick(tbl[8].in, 1'b0);
        check("rst_run", 64'(last_ctl), 64'(C_BR));

        // random traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            v = mk($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3),
                   1'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), $urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 99) == 0);
            tick(v, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
